// File: rtl/space_wire_stat_readout.sv
// ---------------------------------------------------------------------------
// space_wire_stat_readout
//
// Host-side readout stage for the SpaceWire statistics block. Presents the
// eight 8-bit statistics counters and the 7-bit character monitor through a
// req/ack register port with coherent snapshots, sticky event flags and a
// statistics-clear strobe.
//
// Optional feature macro: SPW_STAT_IRQ_EN
//   defined   -> register 0xB is a 7-bit IRQ mask, o_irq port present
//   undefined -> 0xB is unmapped, no o_irq port
//
// Parameters
//   STAT_CLR_CYCLES  width of o_stat_clear in i_clk cycles (1..15)
//
// Ports
//   i_clk             system clock
//   i_reset           asynchronous, active-high reset
//   i_stat_info_0..7  txEOP, rxEOP, txEEP, rxEEP, txByte, rxByte, linkUp, linkDown
//   i_char_mon        {rxEEP, rxEOP, FCT, NULL, rxByte, txByte, linkUpEn}
//   i_req             access request, held until o_ack
//   i_we              1 = write, 0 = read
//   i_addr            register address
//   i_wdata           write data
//   o_ack             one-cycle acknowledge
//   o_rdata           read data, valid with o_ack, held until the next ack
//   o_stat_clear      clear strobe to the statistics block
//   o_irq             interrupt (SPW_STAT_IRQ_EN only)
//
// Register map
//   0x0       read: snapshot all eight counters, return counter 0
//   0x1..0x7  read: snapshotted counter n
//   0x8       read: {0, sticky}, clear-on-read (set wins)
//   0x9       read: {0, i_char_mon}
//   0xA       write: bit0 start clear pulse, bit1 force snapshot
//             read : {7'b0, clear_busy}
//   0xB       IRQ mask (SPW_STAT_IRQ_EN only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module space_wire_stat_readout #(
  parameter int unsigned STAT_CLR_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_stat_info_0,
  input  logic [7:0] i_stat_info_1,
  input  logic [7:0] i_stat_info_2,
  input  logic [7:0] i_stat_info_3,
  input  logic [7:0] i_stat_info_4,
  input  logic [7:0] i_stat_info_5,
  input  logic [7:0] i_stat_info_6,
  input  logic [7:0] i_stat_info_7,
  input  logic [6:0] i_char_mon,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_ack,
  output logic [7:0] o_rdata,
  output logic       o_stat_clear
`ifdef SPW_STAT_IRQ_EN
  ,
  output logic       o_irq
`endif
);

  localparam logic [3:0] CLR_LOAD = 4'(STAT_CLR_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACK,
    ST_WAIT_LOW
  } state_t;

  state_t          state_q, state_d;

  logic            we_q;
  logic [3:0]      addr_q;
  logic [7:0]      wdata_q;

  logic [7:0][7:0] stat_in;
  logic [7:0][7:0] shadow_q, shadow_d;
  logic [6:0]      sticky_q, sticky_d;
  logic [3:0]      clr_cnt_q, clr_cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            clr_busy;
  logic            decode;

`ifdef SPW_STAT_IRQ_EN
  logic [6:0]      mask_q, mask_d;
  logic            irq_q;
  logic            unused_wdata;
  assign unused_wdata = wdata_q[7];
`else
  logic            unused_wdata;
  assign unused_wdata = ^wdata_q[7:2];
`endif

  assign stat_in = {i_stat_info_7, i_stat_info_6, i_stat_info_5, i_stat_info_4,
                    i_stat_info_3, i_stat_info_2, i_stat_info_1, i_stat_info_0};

  assign clr_busy     = (clr_cnt_q != '0);
  assign o_stat_clear = clr_busy;
  assign o_rdata      = rdata_q;
  assign decode       = (state_q == ST_DECODE);

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        o_ack   = 1'b1;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // A request still held from the last access must drop first.
        if (!i_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && i_req) begin
      we_q    <= i_we;
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Register file next-state
  // ---------------------------------------------------------------------
  always_comb begin
    shadow_d  = shadow_q;
    sticky_d  = sticky_q | i_char_mon;
    clr_cnt_d = clr_busy ? (clr_cnt_q - 4'd1) : clr_cnt_q;
    rdata_d   = rdata_q;
`ifdef SPW_STAT_IRQ_EN
    mask_d    = mask_q;
`endif
    if (decode) begin
      rdata_d = '0;
      if (we_q) begin
        case (addr_q)
          4'hA: begin
            // Reload rather than accumulate: a busy pulse is only extended.
            if (wdata_q[0]) begin
              clr_cnt_d = CLR_LOAD;
            end
            if (wdata_q[1]) begin
              shadow_d = stat_in;
            end
          end
`ifdef SPW_STAT_IRQ_EN
          4'hB: begin
            mask_d = wdata_q[6:0];
          end
`endif
          default: begin
          end
        endcase
      end else begin
        case (addr_q)
          4'h0: begin
            // Snapshot and return counter 0 straight from the inputs so the
            // returned value matches what was just captured.
            shadow_d = stat_in;
            rdata_d  = stat_in[0];
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            rdata_d = shadow_q[addr_q[2:0]];
          end
          4'h8: begin
            // Events active in the clearing cycle survive the clear.
            rdata_d  = {1'b0, sticky_q};
            sticky_d = i_char_mon;
          end
          4'h9: begin
            rdata_d = {1'b0, i_char_mon};
          end
          4'hA: begin
            rdata_d = {7'b0, clr_busy};
          end
`ifdef SPW_STAT_IRQ_EN
          4'hB: begin
            rdata_d = {1'b0, mask_q};
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q  <= '0;
      sticky_q  <= '0;
      clr_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      sticky_q  <= sticky_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef SPW_STAT_IRQ_EN
  // ---------------------------------------------------------------------
  // Interrupt: registered, follows sticky/mask by one cycle
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(sticky_q & mask_q);
    end
  end

  assign o_irq = irq_q;
`endif

endmodule
